load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle data-memory front end directly downstream of the single-cycle core datapath.
- Takes the datapath's ALUResult (address) and WriteData (store data), plus funct3 and mem-op strobes from the control unit.
- Drives a valid/ready data bus with byte enables, and returns aligned, sign/zero-extended ReadData to the Result mux.
- Stalls the core (PC hold, RegWrite suppress) until the access completes.

Parameters:
- ADDR_W, 32, byte-address width of req_addr and mem_addr.
- TIMEOUT_CYCLES, 255, max cycles waiting for mem_rvalid before bus_err; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  core has a load/store this instruction
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address (ALUResult)
- req_wdata  in  32  store data (WriteData)
- stall  out  1  core must hold PC and suppress RegWrite
- done  out  1  one-cycle pulse: access complete, rdata valid for loads
- rdata  out  32  extended load data (ReadData)
- bus_err  out  1  timeout flag, valid with done
- fault  out  1  misalignment/illegal-funct3 flag, valid with done (see Optional Feature)
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accepts request
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word

Behaviour:
- Reset: state IDLE; all outputs 0; rdata = 0; capture registers and timeout counter cleared. Asserting reset mid-access drops mem_valid immediately; the bus tolerates the abort.
- stall = req_valid & (state != DONE), combinational.
- IDLE:
  - On req_valid, register addr, we, funct3, wdata, and computed be/wdata, then go to REQ.
  - Core inputs are ignored after capture.
- REQ:
  - mem_valid = 1; mem_addr, mem_we, mem_be, mem_wdata held stable until mem_ready.
  - mem_ready & store -> DONE.
  - mem_ready & load & mem_rvalid -> DONE, capturing data.
  - mem_ready & load & no mem_rvalid -> WAIT.
- WAIT:
  - mem_valid = 0; the counter increments each cycle.
  - mem_rvalid -> DONE, capturing extended data.
  - Counter reaching TIMEOUT_CYCLES (nonzero) -> DONE with bus_err = 1, rdata = 0.
- DONE:
  - done = 1 for exactly one cycle, stall = 0; the core retires the instruction this edge.
  - Then go to IDLE; bus_err/fault clear.
  - A back-to-back memory instruction is seen in IDLE the next cycle.
- Minimum latency: store 3 cycles (IDLE, REQ, DONE); load 3 cycles if mem_rvalid arrives with mem_ready, else 4 or more.
- Store lanes:
  - B: be = 4'b0001 << addr[1:0]; wdata = byte replicated x4.
  - H: be = addr[1] ? 1100 : 0011; wdata = halfword replicated x2.
  - W: be = 1111.
- Load extract: select the byte/half lane by addr[1:0]/addr[1]. Funct3 000/001 sign-extend; 100/101 zero-extend; 010 passes the word.
- rdata holds its last load value until the next load completes; stores leave it unchanged.
- The timeout counter is wide enough for TIMEOUT_CYCLES and clears on entry to WAIT.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misalignment is H/HU/SH with addr[0] = 1, or W/SW with addr[1:0] != 0. Illegal funct3 is 011, 110, 111, or 1xx on a store.
  - Either case is detected in IDLE: no bus request; IDLE -> DONE directly (2-cycle stall); done = 1, fault = 1, rdata = 0.
- Undefined:
  - fault tied 0.
  - Illegal funct3 is treated as W.
  - Misaligned addresses use the lane from the aligned interpretation (H uses addr[1] only, W ignores addr[1:0]).

Test Plan:
- SB addr 0x103, wdata 0x000000A5, mem_ready on first REQ cycle -> mem_addr 0x100, mem_be 1000, mem_wdata 0xA5A5A5A5, done in cycle 3.
- LB addr 0x202, mem_rdata 0x12F03456, rvalid 2 cycles after ready -> rdata 0xFFFFFFF0; LBU same -> 0x000000F0; stall high until done.
- LH addr 0x002, mem_rdata 0x80017FFF -> rdata 0xFFFF8001; LHU -> 0x00008001.
- Load with mem_ready held low 5 cycles -> mem_valid and mem_addr stable for all 5 cycles, stall high throughout.
- TIMEOUT_CYCLES = 4, mem_rvalid never asserted -> done with bus_err = 1, rdata = 0, then IDLE.
- Reset driven low during WAIT -> mem_valid, stall, done go 0 immediately. With MISALIGN_TRAP_EN, LW addr 0x006 -> no mem_valid, done + fault in cycle 2.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory front end for the single-cycle core.
// Captures a load/store from the datapath, runs one valid/ready bus transaction
// with byte enables, and returns the aligned, extended load data. The core is
// stalled until the access retires.
// Optional build macro: MISALIGN_TRAP_EN. When it is defined, misaligned and
// illegal-funct3 accesses complete with fault and never reach the bus.
module load_store_unit #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              bus_err,
    output logic              fault,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned CNT_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [1:0]        lane_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              bus_err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [1:0]        size_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic              trap_d;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;

    // Decode access size; unknown encodings fall back to a full word
    always_comb begin
        size_d = SZ_W;
        if (req_we) begin
            case (req_funct3)
                3'b000:  size_d = SZ_B;
                3'b001:  size_d = SZ_H;
                default: size_d = SZ_W;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: size_d = SZ_B;
                3'b001, 3'b101: size_d = SZ_H;
                default:        size_d = SZ_W;
            endcase
        end
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
        case (size_d)
            SZ_B: begin
                be_d    = 4'b0001 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{req_wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = req_wdata;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic illegal_d;
    logic misalign_d;
    logic fault_q;

    assign illegal_d  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    assign misalign_d = ((size_d == SZ_H) && req_addr[0]) ||
                        ((size_d == SZ_W) && (req_addr[1:0] != 2'b00));
    assign trap_d     = illegal_d || misalign_d;
    assign fault      = fault_q;
`else
    assign trap_d = 1'b0;
    assign fault  = 1'b0;
`endif

    // Lane select and sign/zero extension of the returned bus word
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_B:    load_ext = {{24{sign_q & byte_sel[7]}}, byte_sel};
            SZ_H:    load_ext = {{16{sign_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // Capture the core request when it is accepted in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            sign_q  <= 1'b0;
            lane_q  <= 2'd0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if ((state == S_IDLE) && req_valid) begin
            addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
            we_q    <= req_we;
            size_q  <= size_d;
            sign_q  <= ~req_funct3[2];
            lane_q  <= req_addr[1:0];
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // Access sequencing, load data capture, timeout and completion flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
`ifdef MISALIGN_TRAP_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (trap_d) begin
                            state   <= S_DONE;
                            rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
                            fault_q <= 1'b1;
`endif
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        if (we_q) begin
                            state <= S_DONE;
                        end else if (mem_rvalid) begin
                            rdata_q <= load_ext;
                            state   <= S_DONE;
                        end else begin
                            cnt_q <= '0;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= load_ext;
                        state   <= S_DONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                        rdata_q   <= '0;
                        bus_err_q <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    bus_err_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                    fault_q   <= 1'b0;
`endif
                end
            endcase
        end
    end

    // Reset is folded into stall so an abort releases the core without waiting for an edge
    assign stall     = reset & req_valid & (state != S_DONE);
    assign done      = (state == S_DONE);
    assign rdata     = rdata_q;
    assign bus_err   = bus_err_q;
    assign mem_valid = (state == S_REQ);
    assign mem_we    = (state == S_REQ) & we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit. The bench plays
// both the core and the memory bus, and predicts every result from a
// byte-offset arithmetic reference model.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        bus_err;
    logic        fault;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] last_rd = '0;

    load_store_unit #(
        .ADDR_W(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_we(req_we),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .stall(stall),
        .done(done),
        .rdata(rdata),
        .bus_err(bus_err),
        .fault(fault),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_be(mem_be),
        .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Access size in bytes
    function automatic int model_size(input logic we, input logic [2:0] f3);
        int nb;
        if (we) nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else    nb = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        return nb;
    endfunction

    function automatic bit model_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        bit trap_on;
        bit illegal;
        bit misaligned;
        int nb;
`ifdef MISALIGN_TRAP_EN
        trap_on = 1'b1;
`else
        trap_on = 1'b0;
`endif
        nb         = model_size(we, f3);
        illegal    = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
        misaligned = (int'(addr[1:0]) % nb) != 0;
        return trap_on && (illegal || misaligned);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] word);
        longint v;
        int nb;
        int off;
        nb  = model_size(1'b0, f3);
        off = (nb == 4) ? 0 : (int'(lo) / nb) * nb;
        v   = longint'(word);
        v   = (v >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
        if (nb < 4 && !f3[2] && ((v >> (8 * nb - 1)) != 0))
            v = v - (longint'(1) << (8 * nb));
        return 32'(v);
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] wd,
                               output logic [3:0] be, output logic [31:0] wdat);
        int nb;
        int off;
        nb  = model_size(1'b1, f3);
        off = (nb == 4) ? 0 : (int'(lo) / nb) * nb;
        be  = 4'(((1 << nb) - 1) << off);
        if (nb == 1)      wdat = 32'(wd[7:0]) * 32'h01010101;
        else if (nb == 2) wdat = 32'(wd[15:0]) * 32'h00010001;
        else              wdat = wd;
    endtask

    // One complete access; entered and left just after a rising edge
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int rdel, input int vdel,
                          input logic [31:0] word, input bit no_rvalid);
        bit          flt;
        bit          got_done;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        int          exp_dc;
        int          ready_cyc;
        bit          exp_mv;

        flt = model_fault(we, f3, addr);
        model_store(f3, addr[1:0], wd, exp_be, exp_wd);
        if (flt)            exp_rd = '0;
        else if (we)        exp_rd = last_rd;
        else if (no_rvalid) exp_rd = '0;
        else                exp_rd = model_load(f3, addr[1:0], word);
        ready_cyc = 2 + rdel;
        if (flt)            exp_dc = 2;
        else if (we)        exp_dc = ready_cyc + 1;
        else if (no_rvalid) exp_dc = ready_cyc + 1 + int'(TO);
        else                exp_dc = ready_cyc + 1 + vdel;

        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        got_done   = 1'b0;

        for (int c = 1; c <= 60; c++) begin
            mem_ready  = !flt && (c == ready_cyc);
            mem_rvalid = !flt && !we && !no_rvalid && (c == ready_cyc + vdel);
            mem_rdata  = mem_rvalid ? word : $urandom();
            @(negedge clk);
            exp_mv = !flt && (c >= 2) && (c <= ready_cyc);
            check("mem_valid", 32'(mem_valid), 32'(exp_mv));
            if (exp_mv) begin
                check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                check("mem_we", 32'(mem_we), 32'(we));
                if (we) begin
                    check("mem_be", 32'(mem_be), 32'(exp_be));
                    check("mem_wdata", mem_wdata, exp_wd);
                end
            end
            if (done) begin
                got_done = 1'b1;
                check("done_cycle", 32'(c), 32'(exp_dc));
                check("stall_at_done", 32'(stall), 32'd0);
                check("rdata", rdata, exp_rd);
                check("bus_err", 32'(bus_err), 32'(!flt && !we && no_rvalid));
                check("fault", 32'(fault), 32'(flt));
                break;
            end
            check("stall_busy", 32'(stall), 32'd1);
            @(posedge clk);
            #1;
        end
        if (!got_done) check("done_seen", 32'd0, 32'd1);
        last_rd = exp_rd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_bus_err", 32'(bus_err), 32'd0);
        check("idle_fault", 32'(fault), 32'd0);
        check("idle_rdata", rdata, last_rd);
        @(posedge clk);
        #1;
    endtask

    // Abort a load with reset, either while requesting or while waiting for data
    task automatic reset_mid(input bit in_wait);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        if (in_wait) begin
            mem_ready = 1'b1;
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            check("wait_mem_valid", 32'(mem_valid), 32'd0);
            check("wait_stall", 32'(stall), 32'd1);
        end else begin
            check("req_mem_valid", 32'(mem_valid), 32'd1);
        end
        reset = 1'b0;
        #1;
        check("abort_mem_valid", 32'(mem_valid), 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        last_rd   = '0;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #12;
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 0, 0, 32'h0, 1'b0);
        run_op(1'b0, 3'b000, 32'h202, 32'h0, 0, 2, 32'h12F0_3456, 1'b0);
        run_op(1'b0, 3'b100, 32'h202, 32'h0, 0, 2, 32'h12F0_3456, 1'b0);
        run_op(1'b0, 3'b001, 32'h002, 32'h0, 0, 0, 32'h8001_7FFF, 1'b0);
        run_op(1'b0, 3'b101, 32'h002, 32'h0, 1, 1, 32'h8001_7FFF, 1'b0);
        run_op(1'b0, 3'b010, 32'h300, 32'h0, 5, 1, 32'hDEAD_BEEF, 1'b0);
        run_op(1'b1, 3'b010, 32'h304, 32'hCAFE_F00D, 2, 0, 32'h0, 1'b0);
        idle_cycle();
        run_op(1'b0, 3'b010, 32'h400, 32'h0, 1, 0, 32'h0, 1'b1);
        idle_cycle();
        run_op(1'b0, 3'b010, 32'h006, 32'h0, 0, 0, 32'h1357_9BDF, 1'b0);
        idle_cycle();
        reset_mid(1'b0);
        reset_mid(1'b1);
        idle_cycle();

        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            if (we) f3 = ($urandom_range(0, 3) == 3) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            else    f3 = 3'($urandom_range(0, 7));
            addr = $urandom();
            run_op(we, f3, addr, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom(), !we && ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
